// File: rtl/opti_out_capture.sv
// opti_out_capture
//   Output stage behind the 4-section Chebyshev II IIR. Captures the filtered
//   Q2.22 stream into an on-chip buffer. Once the filter run ends, it drains the
//   buffer over a valid/ready read port and reports the sample count, the peak
//   magnitude and two sticky error flags.
//
// Ports
//   clk, rst        clock; synchronous active-high reset
//   cap_start       arm pulse (honoured in IDLE/DONE only)
//   in_valid/in_data/in_addr/in_done/in_stable
//                   filtered sample stream and run control from the filter
//   rd_valid/rd_ready/rd_data/rd_addr/rd_last
//                   buffered read port, one word per cycle when ready
//   busy            capture or drain in progress
//   cap_done        one-cycle pulse on entry to DONE
//   sample_count    accepted samples, 0..DEPTH
//   peak_abs        largest |sample| captured (saturated)
//   overflow        sticky: sample dropped on a full buffer
//   addr_err        sticky: in_addr disagreed with the write pointer
module opti_out_capture #(
  parameter int DATA_W      = 24,
  parameter int ADDR_W      = 11,
  parameter int DEPTH       = 2048,
  parameter int WAIT_STABLE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cap_start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic              in_done,
  input  logic              in_stable,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_last,
  output logic              busy,
  output logic              cap_done,
  output logic [ADDR_W:0]   sample_count,
  output logic [DATA_W-1:0] peak_abs,
  output logic              overflow,
  output logic              addr_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_CAPTURE,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [ADDR_W:0]   PTR_ONE = (ADDR_W+1)'(1);
  localparam logic [DATA_W-1:0] DAT_ONE = DATA_W'(1);
  localparam logic [DATA_W-1:0] MAX_POS = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};

  state_t state, state_nx;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W:0]   wptr;
  logic [ADDR_W:0]   rptr;
  logic [ADDR_W:0]   last_idx;
  logic              full;
  logic              accept;
  logic              wr_en;
  logic              arm;
  logic              hs;
  logic [DATA_W-1:0] abs_v;
  logic [DATA_W-1:0] pk_val;
  logic              pk_pend;

  // DEPTH == 2**ADDR_W, so the pointer MSB alone marks a full buffer.
  assign full         = wptr[ADDR_W];
  assign last_idx     = wptr - PTR_ONE;
  assign hs           = rd_valid & rd_ready;
  assign arm          = cap_start & ((state == S_IDLE) | (state == S_DONE));
  assign sample_count = wptr;
  assign busy         = (state == S_ARMED) | (state == S_CAPTURE) | (state == S_DRAIN);

  always_comb begin
    accept = 1'b0;
    if (state == S_CAPTURE)
      accept = in_valid;
    else if (state == S_ARMED)
      accept = in_valid & ((WAIT_STABLE == 0) | in_stable);
  end

  assign wr_en = accept & ~full;

  // Most negative value has no positive twin; saturate it.
  always_comb begin
    abs_v = in_data;
    if (in_data == MIN_NEG)
      abs_v = MAX_POS;
    else if (in_data[DATA_W-1])
      abs_v = ~in_data + DAT_ONE;
  end

  always_ff @(posedge clk) begin
    if (rst)
      state <= S_IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:    if (cap_start) state_nx = S_ARMED;
      S_ARMED: begin
        // The entry sample may coincide with in_done; it is written first.
        if (in_done)
          state_nx = wr_en ? S_DRAIN : S_DONE;
        else if (accept)
          state_nx = S_CAPTURE;
      end
      S_CAPTURE: if (in_done) state_nx = ((wptr != '0) | wr_en) ? S_DRAIN : S_DONE;
      S_DRAIN:   if (hs & rd_last) state_nx = S_DONE;
      S_DONE:    if (cap_start) state_nx = S_ARMED;
      default:   state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wptr[ADDR_W-1:0]] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      overflow <= 1'b0;
      addr_err <= 1'b0;
      peak_abs <= '0;
      pk_val   <= '0;
      pk_pend  <= 1'b0;
      cap_done <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      rd_addr  <= '0;
      rd_last  <= 1'b0;
    end else begin
      if (wr_en) begin
        wptr   <= wptr + PTR_ONE;
        pk_val <= abs_v;
        if (in_addr != wptr[ADDR_W-1:0])
          addr_err <= 1'b1;
      end
      if (accept & full)
        overflow <= 1'b1;

      // Peak compare is staged one cycle behind the write.
      pk_pend <= wr_en;
      if (pk_pend && (pk_val > peak_abs))
        peak_abs <= pk_val;

      cap_done <= (state_nx == S_DONE) & (state != S_DONE);

      // Output register refills on the handshake cycle itself (read-ahead),
      // so a continuously ready consumer sees one word per cycle.
      if ((state == S_DRAIN) && (!rd_valid || rd_ready)) begin
        if (rd_valid && rd_last) begin
          rd_valid <= 1'b0;
          rd_last  <= 1'b0;
        end else begin
          rd_data  <= mem[rptr[ADDR_W-1:0]];
          rd_addr  <= rptr[ADDR_W-1:0];
          rd_last  <= (rptr == last_idx);
          rd_valid <= 1'b1;
          rptr     <= rptr + PTR_ONE;
        end
      end

      if (arm) begin
        wptr     <= '0;
        rptr     <= '0;
        overflow <= 1'b0;
        addr_err <= 1'b0;
        peak_abs <= '0;
        pk_pend  <= 1'b0;
      end
    end
  end

endmodule

// File: doc/opti_out_capture.md
Name: opti_out_capture

Overview:
- Downstream stage of the 4-section Chebyshev II IIR top level.
- Consumes the filtered Q2.22 stream (data, valid, addr, filter_done, stable) into an on-chip sample buffer.
- After the filter run completes, drains the buffer over a valid/ready read port to the host/bench side.
- Reports sample count, peak magnitude and sticky error flags.

Parameters:
- DATA_W, 24, sample width (Q2.22 signed).
- ADDR_W, 11, buffer address width.
- DEPTH, 2048, buffer entries; must equal 2**ADDR_W.
- WAIT_STABLE, 1, when 1, capture begins only at the first valid sample with in_stable=1.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- cap_start  in  1  arm pulse; accepted in IDLE or DONE.
- in_valid  in  1  filtered sample valid.
- in_data  in  DATA_W  filtered sample, signed.
- in_addr  in  ADDR_W  sample index from the filter control.
- in_done  in  1  filter_done pulse, end of run.
- in_stable  in  1  filter output settled.
- rd_valid  out  1  read word valid.
- rd_ready  in  1  consumer ready.
- rd_data  out  DATA_W  buffered sample.
- rd_addr  out  ADDR_W  index of rd_data, 0..count-1.
- rd_last  out  1  rd_data is the final word.
- busy  out  1  state is not IDLE and not DONE.
- cap_done  out  1  one-cycle pulse on entry to DONE.
- sample_count  out  ADDR_W+1  accepted samples, 0..DEPTH.
- peak_abs  out  DATA_W  max |sample| captured.
- overflow  out  1  sticky: a sample was dropped because the buffer was full.
- addr_err  out  1  sticky: in_addr differed from the internal write pointer.

Behaviour:
- Reset (rst=1 at an edge), from any state including mid-drain: state=IDLE; all outputs, write pointer and read pointer = 0. Buffer contents are don't-care.
- States: IDLE, ARMED, CAPTURE, DRAIN, DONE.
- IDLE -> ARMED on cap_start. On that edge, clear sample_count, peak_abs, overflow, addr_err and both pointers.
- ARMED -> CAPTURE:
  - WAIT_STABLE=1: on the first cycle with in_valid & in_stable; that sample is written.
  - WAIT_STABLE=0: on the first in_valid.
  - Valids before that are dropped silently.
- Write in CAPTURE (including the entry sample):
  - If in_valid and wptr<DEPTH: mem[wptr]=in_data; wptr and sample_count +1.
  - If in_addr!=wptr[ADDR_W-1:0], set addr_err; data is still stored at wptr.
  - If wptr==DEPTH: sample dropped, overflow set, state unchanged.
- Peak: |x| computed per written sample; |-2^(DATA_W-1)| saturates to 2^(DATA_W-1)-1. peak_abs updates on the cycle after the write.
- in_done in CAPTURE:
  - A simultaneous in_valid sample is written first.
  - Next state is DRAIN if the post-write count>0, else DONE.
  - in_done in ARMED -> DONE with count 0.
- DRAIN:
  - Synchronous buffer read, 1-cycle latency, with read-ahead.
  - rd_valid first asserts 1 cycle after DRAIN entry.
  - Throughput is one word per cycle while rd_ready=1.
  - rd_data, rd_addr and rd_last are held stable while rd_valid & !rd_ready.
  - Handshake completes on rd_valid & rd_ready.
  - rd_last=1 when rd_addr==sample_count-1; the handshake on the last word -> DONE next cycle, rd_valid=0.
- DONE: cap_done high exactly one cycle on entry. Stats are held. cap_start -> ARMED (clear as above).
- Ignored inputs:
  - cap_start outside IDLE/DONE.
  - in_valid and in_done outside ARMED/CAPTURE.
- rd_valid is never asserted outside DRAIN.

Test Plan:
- Stream: WAIT_STABLE=1, cap_start; 3 valids with stable=0, then 100 valids (addr 0..99, data=addr*1000) with stable=1, then in_done. Required: sample_count=100; drain with rd_ready=1 yields 100 consecutive rd_valid cycles, rd_data=0,1000,…,99000, rd_last only on rd_addr=99; cap_done pulses once; addr_err=0.
- Backpressure: drain of 4 samples with rd_ready toggled 1,0,0,1,… Required: each word held stable while stalled; order preserved; exactly 4 handshakes.
- Full buffer: 2050 valids then in_done. Required: sample_count=2048, overflow=1, last drained rd_addr=2047.
- Peak and address error: samples -8388608 and 1234567, second with in_addr=5. Required: peak_abs=8388607, addr_err=1, data stored at index 1.
- Edge cases:
  - in_done together with the first valid -> count=1, one word drained.
  - in_done while ARMED -> DONE, rd_valid never 1.
- Reset mid-drain at word 10 -> next cycle rd_valid=0, busy=0, sample_count=0; a new capture works normally.
